tx_prbs_randomizer: RTL
=======================

Name: tx_prbs_randomizer

Overview:
- Upstream stage that feeds the OFDM transmitter's 6-bit input stream.
- Applies the 802.16 data randomizer (polynomial 1+x^14+x^15) to 4-bit data nibbles, 4 bits per clock, MSB first.
- Reseeds the randomizer at the start of every burst. A burst is bounded by CYC_I.
- Presents results on a Wishbone-style streaming master port through a 2-entry output buffer, so throughput is 1 nibble/clk under downstream backpressure.

Parameters:
- SEED, 15'h00A9, initial randomizer state; bit i = LFSR stage i+1 (802.16 seed 100101010000000, stage1..stage15).
- DW_OUT, 6, output data width; bits [DW_OUT-1:4] driven 0.

Ports:
- CLK_I  in  1  system clock, all logic on rising edge
- RST_I  in  1  synchronous reset, active-high
- DAT_I  in  4  plain data nibble, bit 3 transmitted first
- CYC_I  in  1  burst in progress (upstream)
- STB_I  in  1  DAT_I valid
- WE_I   in  1  write cycle; must be 1 for a transfer
- ACK_O  out 1  nibble accepted this cycle
- DAT_O  out DW_OUT  randomized nibble in [3:0], upper bits 0
- CYC_O  out 1  burst in progress (downstream)
- STB_O  out 1  DAT_O valid
- WE_O   out 1  equals CYC_O
- ACK_I  in  1  downstream accepted DAT_O

Behaviour:
- Clock and reset: one clock, CLK_I. RST_I is synchronous and active-high.
- Reset values: ACK_O=0, DAT_O=0, CYC_O=0, STB_O=0, WE_O=0. FIFO count=0. LFSR state s=SEED.
- Input transfer: occurs when CYC_I & STB_I & WE_I & ACK_O.
  - ACK_O = CYC_I & STB_I & WE_I & (count<2), combinational.
  - A full buffer never accepts, even if a pop happens in the same cycle.
- Randomizer: state s[14:0], s[0]=stage1. Per bit k = 3,2,1,0 in sequence within one clock:
  - fb = s[13]^s[14]
  - out[k] = DAT_I[k]^fb
  - s = {s[13:0], fb}
  - The 4-bit result and the 4-step-advanced state are computed combinationally from the current s.
  - s updates only on an input transfer.
- Reseed: while CYC_I=0, s is loaded with SEED every cycle. The first nibble of each burst therefore always uses SEED.
- Output buffer: 2-entry FIFO holding registered randomized nibbles.
  - STB_O = (count!=0). DAT_O = head entry, or 0 when empty.
  - Output transfer (pop) occurs when STB_O & ACK_I.
  - Simultaneous push and pop: count unchanged, order preserved.
  - ACK_I while STB_O=0 is ignored.
- Latency: a nibble accepted in cycle n appears on DAT_O with STB_O=1 in cycle n+1, if the buffer was empty.
- Throughput: steady state 1 nibble/clk with ACK_I held 1.
- CYC_O:
  - Set in the cycle after the first input transfer of a burst.
  - Cleared in the cycle after CYC_I=0 and count=0 are both true, i.e. the burst is drained.
  - A new burst may not restart CYC_O until it has cleared for at least one cycle.
- CYC_I dropping with data still buffered: buffered data drains normally, and reseed happens immediately.
- STB_I without WE_I: no transfer, ACK_O=0.
- Reset mid-burst: the buffer is flushed and any in-flight nibbles are discarded. Outputs go to reset values the next cycle.

Test Plan:
- All-zero data, ACK_I=1: reset, CYC_I=1, 4 nibbles 0x0 -> DAT_O sequence 0x0, 0x3, 0xF, 0x6 on 4 consecutive cycles, first one cycle after the first ACK_O.
- Reseed: burst of 0x0,0x0 -> 0x0,0x3; drop CYC_I 1 cycle; new burst of 0x0,0x0 -> 0x0,0x3 again. CYC_O deasserts for at least 1 cycle between bursts.
- Backpressure: ACK_I=0, STB_I=1 continuously -> ACK_O high for exactly 2 cycles then 0. Release ACK_I -> output stays in order (0x0, 0x3, 0xF, ...) with no loss or duplication.
- Non-zero data: DAT_I=0xF x4 from SEED -> DAT_O 0xF, 0xC, 0x0, 0x9 (bitwise inverse of the all-zero case).
- Simultaneous push/pop at count=1 for 20 cycles -> count stays 1 and ACK_O stays high. Checker compares every output against a golden bit-serial LFSR model.
- Reset mid-burst with 2 nibbles buffered -> next cycle STB_O=0, CYC_O=0, ACK_O=0. Next burst starts from SEED (first output 0x0 for input 0x0).

Source files
------------

// File: rtl/tx_prbs_randomizer.sv
// rtl/tx_prbs_randomizer.sv - 802.16 PRBS data randomizer (1+x^14+x^15), 4 bits/clk,
// reseeded per burst, with a 2-entry Wishbone-style streaming output buffer.
module tx_prbs_randomizer #(
    parameter logic [14:0] SEED   = 15'h00A9,
    parameter int          DW_OUT = 6
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [3:0]        DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    output logic [DW_OUT-1:0] DAT_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I
);

    logic [14:0] lfsr_q, lfsr_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  buf0_q, buf0_d;
    logic [3:0]  buf1_q, buf1_d;
    logic        cyc_q, cyc_d;

    logic [14:0] lfsr_adv;
    logic [3:0]  rand_nib;
    logic        fb;
    logic        push;
    logic        pop;

    // Four serial LFSR steps unrolled into one clock, bit 3 first.
    always_comb begin
        lfsr_adv = lfsr_q;
        rand_nib = 4'h0;
        fb       = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            fb          = lfsr_adv[13] ^ lfsr_adv[14];
            rand_nib[k] = DAT_I[k] ^ fb;
            lfsr_adv    = {lfsr_adv[13:0], fb};
        end
    end

    assign push = ACK_O;
    assign pop  = STB_O & ACK_I;

    always_comb begin
        lfsr_d  = lfsr_q;
        count_d = count_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        cyc_d   = cyc_q;

        if (!CYC_I) begin
            lfsr_d = SEED;
        end else if (push) begin
            lfsr_d = lfsr_adv;
        end

        if (pop) begin
            buf0_d = buf1_q;
        end
        // Push lands in the slot that will be the tail after any same-cycle pop.
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                buf0_d = rand_nib;
            end else begin
                buf1_d = rand_nib;
            end
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (!cyc_q) begin
            cyc_d = push;
        end else if (!CYC_I && count_q == 2'd0) begin
            cyc_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            lfsr_q  <= SEED;
            count_q <= 2'd0;
            buf0_q  <= 4'h0;
            buf1_q  <= 4'h0;
            cyc_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ACK_O = ~RST_I & CYC_I & STB_I & WE_I & (count_q < 2'd2);
    assign STB_O = (count_q != 2'd0);
    assign DAT_O = STB_O ? {{(DW_OUT-4){1'b0}}, buf0_q} : '0;
    assign CYC_O = cyc_q;
    assign WE_O  = cyc_q;

endmodule
